// File: rtl/mem_port_responder_if.sv
// Request/response bundle for the shared instruction/data memory port.
// resp_err exists only when MEM_PORT_RESPONDER_MISALIGN_ERR_EN is defined.
interface mem_port_responder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              busy;
`ifdef MEM_PORT_RESPONDER_MISALIGN_ERR_EN
  logic              resp_err;
`endif

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, busy
`ifdef MEM_PORT_RESPONDER_MISALIGN_ERR_EN
    , input resp_err
`endif
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, busy
`ifdef MEM_PORT_RESPONDER_MISALIGN_ERR_EN
    , output resp_err
`endif
  );
endinterface

// File: rtl/mem_port_responder.sv
// Multi-cycle byte-addressed little-endian memory responder with fixed wait states.
// Optional misalignment error response: define MEM_PORT_RESPONDER_MISALIGN_ERR_EN.
module mem_port_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;
  logic [7:0]        mem_q [DEPTH_BYTES];

  logic              accept;
  logic              commit;
  logic              op_we;
  logic [2:0]        op_f3;
  logic [ADDR_W-1:0] op_addr;
  logic [31:0]       op_wdata;
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic              f3_ok;
  logic              mis;
  logic              op_ok;
  logic [3:0]        wen;
  logic [31:0]       rdata_d;

  // With zero wait states the commit edge is the accept edge, so the
  // operation is taken straight from the request rather than the latches.
  always_comb begin
    accept   = (state_q == IDLE) && bus.req_valid && !rst;
    commit   = !rst && (((state_q == WAIT) && (cnt_q == '0)) ||
                        (accept && (WAIT_CYCLES == 0)));
    op_we    = (state_q == IDLE) ? bus.req_we     : we_q;
    op_f3    = (state_q == IDLE) ? bus.req_funct3 : f3_q;
    op_addr  = (state_q == IDLE) ? bus.req_addr   : addr_q;
    op_wdata = (state_q == IDLE) ? bus.req_wdata  : wdata_q;

    a0 = op_addr;
    a1 = op_addr + ADDR_W'(1);
    a2 = op_addr + ADDR_W'(2);
    a3 = op_addr + ADDR_W'(3);

    // 011, 110 and 111 are not legal load/store encodings
    f3_ok = !(op_f3[1] && op_f3[0]) && !(op_f3[2] && op_f3[1]);
    mis   = 1'b0;
`ifdef MEM_PORT_RESPONDER_MISALIGN_ERR_EN
    mis   = f3_ok && (((op_f3[1:0] == 2'b01) && op_addr[0]) ||
                      ((op_f3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00)));
`endif
    op_ok = f3_ok && !mis;

    wen = 4'b0000;
    if (commit && op_we && op_ok) begin
      case (op_f3[1:0])
        2'b00:   wen = 4'b0001;
        2'b01:   wen = 4'b0011;
        2'b10:   wen = 4'b1111;
        default: wen = 4'b0000;
      endcase
    end

    rdata_d = '0;
    if (!op_we && op_ok) begin
      case (op_f3[1:0])
        2'b00:   rdata_d = {{24{~op_f3[2] & mem_q[a0][7]}}, mem_q[a0]};
        2'b01:   rdata_d = {{16{~op_f3[2] & mem_q[a1][7]}}, mem_q[a1], mem_q[a0]};
        2'b10:   rdata_d = {mem_q[a3], mem_q[a2], mem_q[a1], mem_q[a0]};
        default: rdata_d = '0;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wen[0]) mem_q[a0] <= op_wdata[7:0];
    if (wen[1]) mem_q[a1] <= op_wdata[15:8];
    if (wen[2]) mem_q[a2] <= op_wdata[23:16];
    if (wen[3]) mem_q[a3] <= op_wdata[31:24];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= commit;
      resp_err_q   <= commit && mis;
      if (commit) resp_rdata_q <= rdata_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
`ifdef MEM_PORT_RESPONDER_MISALIGN_ERR_EN
  assign bus.resp_err   = resp_err_q;
`else
  logic unused_err;
  assign unused_err = resp_err_q;
`endif
endmodule
